// File: rtl/id_pkg.sv
// id_pkg: opcode constants, ALU op encoding, ID/EX payload type and immediate helpers
package id_pkg;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_t;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] op1;
    logic [31:0] op2;
    alu_op_t     alu;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } id_ex_t;
  function automatic logic [31:0] imm_i(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction
  function automatic logic [31:0] imm_u(input logic [19:0] imm);
    return {imm, 12'b0};
  endfunction
  function automatic alu_op_t alu_dec(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/id_fwd_mux.sv
// id_fwd_mux: resolves one source operand from x0, EX result, WB write or regfile data
module id_fwd_mux #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int FWD_EN = 1
) (
  input  logic [RA_W-1:0] addr_i,
  input  logic [XLEN-1:0] rf_data_i,
  input  logic            ex_wen_i,
  input  logic [RA_W-1:0] ex_rd_i,
  input  logic [XLEN-1:0] ex_data_i,
  input  logic            wb_wen_i,
  input  logic [RA_W-1:0] wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic [XLEN-1:0] data_o
);
  assign data_o = FWD_EN == 0 ? rf_data_i :
                  addr_i == '0 ? '0 :
                  ex_wen_i && ex_rd_i == addr_i ? ex_data_i :
                  wb_wen_i && wb_rd_i == addr_i ? wb_data_i : rf_data_i;
endmodule

// File: rtl/id_pipe_stage.sv
// id_pipe_stage: registered RV32I decode stage (OP-IMM/OP/LUI/AUIPC) with forwarding and ID/EX handshake
module id_pipe_stage #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      inst_i,
  input  logic [XLEN-1:0]  inst_addr_i,
  output logic [RA_W-1:0]  rs1_addr_o,
  output logic [RA_W-1:0]  rs2_addr_o,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  input  logic             ex_wen_i,
  input  logic [RA_W-1:0]  ex_rd_i,
  input  logic [XLEN-1:0]  ex_data_i,
  input  logic             wb_wen_i,
  input  logic [RA_W-1:0]  wb_rd_i,
  input  logic [XLEN-1:0]  wb_data_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      inst_o,
  output logic [XLEN-1:0]  inst_addr_o,
  output logic [XLEN-1:0]  op1_o,
  output logic [XLEN-1:0]  op2_o,
  output logic [3:0]       alu_op_o,
  output logic [RA_W-1:0]  rd_addr_o,
  output logic             reg_wen_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] dec_cnt_o
);
  import id_pkg::*;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic is_opimm, is_op, is_lui, is_auipc, is_shift, legal, alt, load;
  logic [XLEN-1:0] rs1_val, rs2_val;
  id_ex_t pl_d, pl_q;
  logic valid_d, valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  assign opc = inst_i[6:0];
  assign f3 = inst_i[14:12];
  assign f7 = inst_i[31:25];
  assign is_opimm = opc == OPC_OPIMM;
  assign is_op = opc == OPC_OP;
  assign is_lui = opc == OPC_LUI;
  assign is_auipc = opc == OPC_AUIPC;
  assign is_shift = f3 == 3'b001 || f3 == 3'b101;
  assign legal = is_opimm ? (f3 == 3'b001 ? f7 == 7'h00 :
                             f3 == 3'b101 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1) :
                 is_op ? (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) :
                 is_lui || is_auipc;
  assign alt = f7[5] && (is_op || f3 == 3'b101);
  assign rs1_addr_o = is_lui ? '0 : inst_i[19:15];
  assign rs2_addr_o = is_op ? inst_i[24:20] : '0;
  id_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W), .FWD_EN(FWD_EN)) u_fwd_rs1 (
    .addr_i(rs1_addr_o), .rf_data_i(rs1_data_i),
    .ex_wen_i(ex_wen_i), .ex_rd_i(ex_rd_i), .ex_data_i(ex_data_i),
    .wb_wen_i(wb_wen_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .data_o(rs1_val)
  );
  id_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W), .FWD_EN(FWD_EN)) u_fwd_rs2 (
    .addr_i(rs2_addr_o), .rf_data_i(rs2_data_i),
    .ex_wen_i(ex_wen_i), .ex_rd_i(ex_rd_i), .ex_data_i(ex_data_i),
    .wb_wen_i(wb_wen_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .data_o(rs2_val)
  );
  assign in_ready_o = !valid_q || out_ready_i;
  assign load = in_valid_i && in_ready_o && !flush_i;
  always_comb begin
    pl_d = pl_q;
    if (load) begin
      pl_d = '0;
      pl_d.inst = inst_i;
      pl_d.pc = inst_addr_i;
      pl_d.ill = !legal;
      pl_d.wen = legal && inst_i[11:7] != 5'd0;
      pl_d.rd = legal ? inst_i[11:7] : 5'd0;
      pl_d.alu = legal && (is_opimm || is_op) ? alu_dec(f3, alt) : ALU_ADD;
      pl_d.op1 = !legal || is_lui ? '0 : is_auipc ? inst_addr_i : rs1_val;
      pl_d.op2 = !legal ? '0 :
                 is_op ? rs2_val :
                 is_lui || is_auipc ? imm_u(inst_i[31:12]) :
                 is_shift ? {27'b0, inst_i[24:20]} : imm_i(inst_i[31:20]);
    end
    valid_d = flush_i ? 1'b0 : load ? 1'b1 : valid_q && !out_ready_i;
    cnt_d = cnt_q + CNT_W'(valid_q && out_ready_i && !flush_i);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pl_q <= '0;
      cnt_q <= '0;
    end else begin
      valid_q <= valid_d;
      pl_q <= pl_d;
      cnt_q <= cnt_d;
    end
  end
  assign out_valid_o = valid_q;
  assign inst_o = pl_q.inst;
  assign inst_addr_o = pl_q.pc;
  assign op1_o = pl_q.op1;
  assign op2_o = pl_q.op2;
  assign alu_op_o = pl_q.alu;
  assign rd_addr_o = pl_q.rd;
  assign reg_wen_o = pl_q.wen;
  assign illegal_o = pl_q.ill;
  assign dec_cnt_o = cnt_q;
endmodule

// File: tb/tb_id_pipe_stage.sv
// tb_id_pipe_stage: table-driven decode vectors plus stall, flush and reset sequences
module tb_id_pipe_stage;
  logic clk = 0;
  logic rst = 0;
  logic in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 0;
  logic [31:0] inst = 0, pc = 0, r1 = 0, r2 = 0, exd = 0, wbd = 0;
  logic exw = 0, wbw = 0;
  logic [4:0] exr = 0, wbr = 0, a1, a2, rd;
  logic [31:0] inst_o, pc_o, op1, op2, cnt;
  logic [3:0] alu;
  logic wen, ill;
  int n_cmp = 0, n_bad = 0;
  typedef struct packed {
    logic [31:0] inst, pc, r1, r2;
    logic exw; logic [4:0] exr; logic [31:0] exd;
    logic wbw; logic [4:0] wbr; logic [31:0] wbd;
    logic [4:0] a1, a2;
    logic [31:0] op1, op2;
    logic [3:0] alu;
    logic [4:0] rd;
    logic wen, ill;
  } vec_t;
  vec_t vt [16];
  always #5 clk = ~clk;
  id_pipe_stage dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .inst_i(inst), .inst_addr_i(pc), .rs1_addr_o(a1), .rs2_addr_o(a2),
    .rs1_data_i(r1), .rs2_data_i(r2),
    .ex_wen_i(exw), .ex_rd_i(exr), .ex_data_i(exd),
    .wb_wen_i(wbw), .wb_rd_i(wbr), .wb_data_i(wbd),
    .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .inst_o(inst_o), .inst_addr_o(pc_o), .op1_o(op1), .op2_o(op2),
    .alu_op_o(alu), .rd_addr_o(rd), .reg_wen_o(wen), .illegal_o(ill),
    .dec_cnt_o(cnt)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic apply(input vec_t v);
    inst = v.inst; pc = v.pc; r1 = v.r1; r2 = v.r2;
    exw = v.exw; exr = v.exr; exd = v.exd;
    wbw = v.wbw; wbr = v.wbr; wbd = v.wbd;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " valid"}, 32'(out_valid), 32'h0);
    chk({tag, " inst"}, inst_o, 32'h0);
    chk({tag, " pc"}, pc_o, 32'h0);
    chk({tag, " op1"}, op1, 32'h0);
    chk({tag, " op2"}, op2, 32'h0);
    chk({tag, " alu"}, 32'(alu), 32'h0);
    chk({tag, " rd"}, 32'(rd), 32'h0);
    chk({tag, " wen"}, 32'(wen), 32'h0);
    chk({tag, " ill"}, 32'(ill), 32'h0);
    chk({tag, " cnt"}, cnt, 32'h0);
  endtask
  initial begin
    #1 rst = 1;
    #1 chk_zero("rst_async");
    step;
    rst = 0;
    chk_zero("rst");
    chk("rst in_ready", 32'(in_ready), 32'h1);
    vt[0]  = '{32'h00500093, 32'h0, 32'hDEAD, 32'h0, 1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h5, 4'd0, 5'd1, 1'b1, 1'b0};
    vt[1]  = '{32'hFFF08113, 32'h0, 32'hC, 32'h0, 1'b1, 5'd1, 32'hA, 1'b1, 5'd1, 32'hB, 5'd1, 5'd0, 32'hA, 32'hFFFFFFFF, 4'd0, 5'd2, 1'b1, 1'b0};
    vt[2]  = '{32'hFFF08113, 32'h0, 32'hC, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 32'hB, 5'd1, 5'd0, 32'hB, 32'hFFFFFFFF, 4'd0, 5'd2, 1'b1, 1'b0};
    vt[3]  = '{32'h402081B3, 32'h0, 32'h10, 32'h3, 1'b1, 5'd5, 32'h999, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 32'h10, 32'h3, 4'd1, 5'd3, 1'b1, 1'b0};
    vt[4]  = '{32'h123452B7, 32'h0, 32'h99, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h12345000, 4'd0, 5'd5, 1'b1, 1'b0};
    vt[5]  = '{32'h00001317, 32'h100, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h100, 32'h1000, 4'd0, 5'd6, 1'b1, 1'b0};
    vt[6]  = '{32'h0000007F, 32'h0, 32'h55, 32'h66, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 4'd0, 5'd0, 1'b0, 1'b1};
    vt[7]  = '{32'h40109093, 32'h0, 32'h55, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd0, 32'h0, 32'h0, 4'd0, 5'd0, 1'b0, 1'b1};
    vt[8]  = '{32'h00000013, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 4'd0, 5'd0, 1'b0, 1'b0};
    vt[9]  = '{32'h4030D213, 32'h0, 32'h80000000, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd0, 32'h80000000, 32'h3, 4'd7, 5'd4, 1'b1, 1'b0};
    vt[10] = '{32'h0F00F413, 32'h0, 32'h12345678, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd0, 32'h12345678, 32'hF0, 4'd9, 5'd8, 1'b1, 1'b0};
    vt[11] = '{32'h022081B3, 32'h0, 32'h10, 32'h3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 32'h0, 32'h0, 4'd0, 5'd0, 1'b0, 1'b1};
    vt[12] = '{32'h4020D4B3, 32'h0, 32'h40, 32'h7, 1'b1, 5'd2, 32'h5, 1'b1, 5'd2, 32'h6, 5'd1, 5'd2, 32'h40, 32'h5, 4'd7, 5'd9, 1'b1, 1'b0};
    vt[13] = '{32'h0020B533, 32'h0, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 32'h11, 5'd1, 5'd2, 32'h11, 32'h2, 4'd4, 5'd10, 1'b1, 1'b0};
    vt[14] = '{32'h01F0D593, 32'h0, 32'hF0F0F0F0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd0, 32'hF0F0F0F0, 32'h1F, 4'd6, 5'd11, 1'b1, 1'b0};
    vt[15] = '{32'h8000A613, 32'h0, 32'h7, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd0, 32'h7, 32'hFFFFF800, 4'd3, 5'd12, 1'b1, 1'b0};
    out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      apply(vt[i]);
      in_valid = 1;
      #1;
      chk($sformatf("v%0d rs1_addr", i), 32'(a1), 32'(vt[i].a1));
      chk($sformatf("v%0d rs2_addr", i), 32'(a2), 32'(vt[i].a2));
      step;
      chk($sformatf("v%0d valid", i), 32'(out_valid), 32'h1);
      chk($sformatf("v%0d inst", i), inst_o, vt[i].inst);
      chk($sformatf("v%0d pc", i), pc_o, vt[i].pc);
      chk($sformatf("v%0d op1", i), op1, vt[i].op1);
      chk($sformatf("v%0d op2", i), op2, vt[i].op2);
      chk($sformatf("v%0d alu", i), 32'(alu), 32'(vt[i].alu));
      chk($sformatf("v%0d rd", i), 32'(rd), 32'(vt[i].rd));
      chk($sformatf("v%0d wen", i), 32'(wen), 32'(vt[i].wen));
      chk($sformatf("v%0d ill", i), 32'(ill), 32'(vt[i].ill));
      chk($sformatf("v%0d cnt", i), cnt, 32'(i));
    end
    in_valid = 0;
    step;
    chk("drain valid", 32'(out_valid), 32'h0);
    chk("drain cnt", cnt, 32'd16);
    apply(vt[3]);
    in_valid = 1;
    out_ready = 0;
    step;
    chk("stall load valid", 32'(out_valid), 32'h1);
    chk("stall load alu", 32'(alu), 32'h1);
    apply(vt[0]);
    for (int k = 0; k < 3; k++) begin
      step;
      chk($sformatf("stall%0d in_ready", k), 32'(in_ready), 32'h0);
      chk($sformatf("stall%0d valid", k), 32'(out_valid), 32'h1);
      chk($sformatf("stall%0d inst", k), inst_o, 32'h402081B3);
      chk($sformatf("stall%0d alu", k), 32'(alu), 32'h1);
      chk($sformatf("stall%0d op1", k), op1, 32'h10);
      chk($sformatf("stall%0d op2", k), op2, 32'h3);
      chk($sformatf("stall%0d cnt", k), cnt, 32'd16);
    end
    in_valid = 0;
    out_ready = 1;
    step;
    chk("release valid", 32'(out_valid), 32'h0);
    chk("release cnt", cnt, 32'd17);
    apply(vt[4]);
    in_valid = 1;
    out_ready = 0;
    step;
    chk("flush pre valid", 32'(out_valid), 32'h1);
    apply(vt[5]);
    flush = 1;
    out_ready = 1;
    #1 chk("flush in_ready", 32'(in_ready), 32'h1);
    step;
    chk("flush valid", 32'(out_valid), 32'h0);
    chk("flush cnt", cnt, 32'd17);
    flush = 0;
    in_valid = 0;
    step;
    chk("flush drop valid", 32'(out_valid), 32'h0);
    chk("flush drop cnt", cnt, 32'd17);
    apply(vt[3]);
    in_valid = 1;
    out_ready = 0;
    step;
    step;
    chk("midrst pre valid", 32'(out_valid), 32'h1);
    #2 rst = 1;
    #1 chk_zero("midrst");
    step;
    rst = 0;
    in_valid = 0;
    out_ready = 1;
    step;
    chk("post rst valid", 32'(out_valid), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
